// File: rtl/jtpopeye_rom_rq_pkg.sv
// Shared constants for the jtpopeye ROM fetch client.
package jtpopeye_rom_rq_pkg;

  localparam int unsigned SDRAM_AW = 22;
  localparam int unsigned LINE_W   = 32;

  localparam logic [1:0] RQ_IDLE = 2'd0;
  localparam logic [1:0] RQ_REQ  = 2'd1;
  localparam logic [1:0] RQ_WAIT = 2'd2;

endpackage

// File: rtl/jtpopeye_rom_rq_if.sv
// SDRAM port bundle between a ROM fetch client (master) and the controller (slave).
interface jtpopeye_rom_rq_if;
  import jtpopeye_rom_rq_pkg::*;

  logic [SDRAM_AW-1:0] sdram_addr;
  logic                sdram_req;
  logic                sdram_ack;
  logic [LINE_W-1:0]   data_read;
  logic                data_rdy;

  modport master (
    output sdram_addr, sdram_req,
    input  sdram_ack, data_read, data_rdy
  );

  modport slave (
    input  sdram_addr, sdram_req,
    output sdram_ack, data_read, data_rdy
  );

endinterface

// File: rtl/jtpopeye_rom_rq.sv
// Byte-read ROM client with a one-line 32-bit cache, fetching lines over the SDRAM port.
module jtpopeye_rom_rq
  import jtpopeye_rom_rq_pkg::*;
#(
  parameter int unsigned         AW     = 16,
  parameter logic [SDRAM_AW-1:0] OFFSET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              downloading,
  input  logic              loop_rst,
  input  logic [AW-1:0]     addr,
  input  logic              cs,
  output logic [7:0]        dout,
  output logic              ok,
  jtpopeye_rom_rq_if.master sdram
);

  localparam int unsigned TW = (AW > 2) ? AW - 2 : 1;

  logic [1:0]          state_q, state_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [TW-1:0]       line_tag_q, line_tag_d;
  logic [TW-1:0]       fetch_tag_q, fetch_tag_d;
  logic                line_valid_q, line_valid_d;
  logic                req_q, req_d;
  logic [SDRAM_AW-1:0] saddr_q, saddr_d;
  logic                ok_d;
  logic [7:0]          dout_d;

  logic [TW-1:0]       cur_tag;
  logic                hit;
  logic                flush;

  assign cur_tag = TW'(addr >> 2);
  assign hit     = line_valid_q && (cur_tag == line_tag_q);
  assign flush   = downloading || loop_rst;

  assign sdram.sdram_req  = req_q;
  assign sdram.sdram_addr = saddr_q;

  // Next-state and registered-output logic; flush overrides every transition.
  always_comb begin
    state_d      = state_q;
    line_d       = line_q;
    line_tag_d   = line_tag_q;
    fetch_tag_d  = fetch_tag_q;
    line_valid_d = line_valid_q;
    req_d        = req_q;
    saddr_d      = saddr_q;
    ok_d         = 1'b0;
    dout_d       = dout;

    if (flush) begin
      state_d      = RQ_IDLE;
      line_valid_d = 1'b0;
      req_d        = 1'b0;
    end else begin
      case (state_q)
        RQ_IDLE: begin
          if (cs) begin
            if (hit) begin
              ok_d   = 1'b1;
              dout_d = line_q[{addr[1:0], 3'b000} +: 8];
            end else begin
              state_d     = RQ_REQ;
              req_d       = 1'b1;
              saddr_d     = OFFSET + (SDRAM_AW'(cur_tag) << 1);
              fetch_tag_d = cur_tag;
            end
          end
        end
        RQ_REQ: begin
          if (sdram.sdram_ack) begin
            req_d = 1'b0;
            // ack and rdy together: treat as ack then rdy
            if (sdram.data_rdy) begin
              line_d       = sdram.data_read;
              line_tag_d   = fetch_tag_q;
              line_valid_d = 1'b1;
              state_d      = RQ_IDLE;
            end else begin
              state_d = RQ_WAIT;
            end
          end
        end
        RQ_WAIT: begin
          if (sdram.data_rdy) begin
            line_d       = sdram.data_read;
            line_tag_d   = fetch_tag_q;
            line_valid_d = 1'b1;
            state_d      = RQ_IDLE;
          end
        end
        default: state_d = RQ_IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RQ_IDLE;
      line_q       <= '0;
      line_tag_q   <= '0;
      fetch_tag_q  <= '0;
      line_valid_q <= 1'b0;
      req_q        <= 1'b0;
      saddr_q      <= OFFSET;
      ok           <= 1'b0;
      dout         <= '0;
    end else begin
      state_q      <= state_d;
      line_q       <= line_d;
      line_tag_q   <= line_tag_d;
      fetch_tag_q  <= fetch_tag_d;
      line_valid_q <= line_valid_d;
      req_q        <= req_d;
      saddr_q      <= saddr_d;
      ok           <= ok_d;
      dout         <= dout_d;
    end
  end

endmodule
